// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: global bus widths, mem-op encodings, mem FSM states and byte-strobe constants
package mem_stage_pkg;
    localparam int REG_DATA_BUS = 32;
    localparam int REG_ADDR_BUS = 5;
    typedef enum logic [3:0] {
        MEM_NONE = 4'd0, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW
    } mem_op_e;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_e;
    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: little-endian lane select with sign/zero extension of a loaded word
module mem_load_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        op,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] data
);
    logic [7:0] b;
    logic [15:0] h;
    always_comb begin
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        data = op == MEM_LB  ? {{(DATA_W-8){b[7]}}, b} :
               op == MEM_LBU ? {{(DATA_W-8){1'b0}}, b} :
               op == MEM_LH  ? {{(DATA_W-16){h[15]}}, h} :
               op == MEM_LHU ? {{(DATA_W-16){1'b0}}, h} : word;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: single-outstanding load/store stage; MEM_ALIGN_CHECK_EN rejects misaligned accesses with align_err_o
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         mem_op_i,
    input  logic [DATA_W-1:0]  mem_addr_i,
    input  logic [DATA_W-1:0]  mem_wdata_i,
    input  logic [DATA_W-1:0]  reg_write_data_i,
    input  logic [RADDR_W-1:0] reg_write_addr_i,
    input  logic               reg_write_en_i,
    output logic               stall_req_o,
    output logic               req_valid_o,
    input  logic               req_ready_i,
    output logic               req_write_o,
    output logic [DATA_W-1:0]  req_addr_o,
    output logic [DATA_W-1:0]  req_wdata_o,
    output logic [3:0]         req_wstrb_o,
    input  logic               resp_valid_i,
    input  logic [DATA_W-1:0]  resp_rdata_i,
    output logic [DATA_W-1:0]  reg_write_data_o,
    output logic [RADDR_W-1:0] reg_write_addr_o,
    output logic               reg_write_en_o,
    output logic               align_err_o
);
    mem_state_e state, state_n;
    logic is_mem, is_st, is_h, is_w, mis, go;
    logic [1:0] off;
    logic [3:0] strb;
    logic [DATA_W-1:0] wdata, ld_data;
    assign is_mem = mem_op_i inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW};
    assign is_st = mem_op_i inside {MEM_SB, MEM_SH, MEM_SW};
    assign is_h = mem_op_i inside {MEM_LH, MEM_LHU, MEM_SH};
    assign is_w = mem_op_i inside {MEM_LW, MEM_SW};
`ifdef MEM_ALIGN_CHECK_EN
    assign mis = (is_h && mem_addr_i[0]) || (is_w && mem_addr_i[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif
    // Offending low bits are masked, so accesses without the check are forced aligned
    assign off = is_w ? 2'b00 : is_h ? {mem_addr_i[1], 1'b0} : mem_addr_i[1:0];
    assign go = is_mem && !mis;
    always_comb begin
        strb = mem_op_i == MEM_SB ? STRB_B << off :
               mem_op_i == MEM_SH ? STRB_H << off :
               mem_op_i == MEM_SW ? STRB_W : STRB_NONE;
        wdata = mem_op_i == MEM_SB ? {4{mem_wdata_i[7:0]}} :
                mem_op_i == MEM_SH ? {2{mem_wdata_i[15:0]}} : mem_wdata_i;
        state_n = state == IDLE ? (go ? REQ : IDLE) :
                  state == REQ  ? (req_ready_i ? WAIT : REQ) :
                  state == WAIT ? (resp_valid_i ? IDLE : WAIT) : IDLE;
    end
    assign stall_req_o = (state == IDLE && go) || state == REQ || (state == WAIT && !resp_valid_i);
    assign req_valid_o = state == REQ;
    assign req_write_o = req_valid_o && is_st;
    assign req_addr_o = req_valid_o ? {mem_addr_i[DATA_W-1:2], 2'b00} : '0;
    assign req_wdata_o = req_valid_o && is_st ? wdata : '0;
    assign req_wstrb_o = req_valid_o ? strb : STRB_NONE;
    mem_load_align #(.DATA_W(DATA_W)) u_align (
        .op(mem_op_i),
        .off(off),
        .word(resp_rdata_i),
        .data(ld_data)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            reg_write_data_o <= '0;
            reg_write_addr_o <= '0;
            reg_write_en_o <= 1'b0;
            align_err_o <= 1'b0;
        end else begin
            state <= state_n;
            align_err_o <= state == IDLE && mis;
            if (state == IDLE) begin
                reg_write_data_o <= is_mem ? '0 : reg_write_data_i;
                reg_write_addr_o <= is_mem ? '0 : reg_write_addr_i;
                reg_write_en_o <= !is_mem && reg_write_en_i;
            end else if (state == WAIT && resp_valid_i) begin
                reg_write_data_o <= is_st ? '0 : ld_data;
                reg_write_addr_o <= reg_write_addr_i;
                reg_write_en_o <= !is_st && reg_write_en_i;
            end
        end
    end
endmodule
